// File: rtl/ts_null_stuffer.sv
// ts_null_stuffer: constant-rate MPEG-TS output stage on the 27 MHz read side
// of a show-ahead FIFO of {P_SYNC, DATA} words. It passes whole packets once
// enough words are buffered, hunts for sync after corruption and reports
// underflow inside a passed packet.
// Optional feature macro: TS_NULL_STUFF_EN
//   defined   : null packets (PID 0x1FFF) fill every slot without a full packet.
//   undefined : no NULL state, NULL_PKT tied low, output is gapped instead.
module ts_null_stuffer #(
   parameter int unsigned PKT_LEN   = 188,
   parameter int unsigned MIN_LEVEL = 188,
   parameter int unsigned USEDW_W   = 11
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [8:0]         FIFO_Q,
   input  logic               FIFO_EMPTY,
   input  logic [USEDW_W-1:0] FIFO_USEDW,
   output logic               FIFO_RDREQ,
   output logic [7:0]         DATA_OUT,
   output logic               D_VALID_OUT,
   output logic               P_SYNC_OUT,
   output logic               NULL_PKT,
   output logic               SYNC_ERR,
   output logic               UNDERFLOW
);

   typedef enum logic [1:0] {
      ST_DECIDE,
      ST_PASS
`ifdef TS_NULL_STUFF_EN
      , ST_NULL
`endif
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_hunt;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_psync;
   logic       r_serr;
   logic       r_uf;
`ifdef TS_NULL_STUFF_EN
   logic       r_null;
   logic [7:0] w_null_byte;
`endif

   logic w_head_sync;
   logic w_level_ok;
   logic w_rdreq;

   assign w_head_sync = (FIFO_Q == 9'h147);
   assign w_level_ok  = (FIFO_USEDW >= USEDW_W'(MIN_LEVEL));

`ifdef TS_NULL_STUFF_EN
   // Null packet header: sync 0x47, PID 0x1FFF, payload-only, then 0xFF stuffing
   always_comb begin
      w_null_byte = 8'hFF;
      case (r_cnt)
         8'd0:    w_null_byte = 8'h47;
         8'd1:    w_null_byte = 8'h1F;
         8'd2:    w_null_byte = 8'hFF;
         8'd3:    w_null_byte = 8'h10;
         default: w_null_byte = 8'hFF;
      endcase
   end
`endif

   // Pop request: discard non-sync heads in DECIDE, stream words in PASS
   always_comb begin
      w_rdreq = 1'b0;
      if (RST) begin
         case (r_state)
            ST_DECIDE: w_rdreq = !FIFO_EMPTY && !w_head_sync;
            ST_PASS:   w_rdreq = !FIFO_EMPTY;
            default:   w_rdreq = 1'b0;
         endcase
      end
   end

   // Packet sequencer with registered outputs (one cycle behind the pop)
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_DECIDE;
         r_cnt   <= '0;
         r_hunt  <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_psync <= 1'b0;
         r_serr  <= 1'b0;
         r_uf    <= 1'b0;
`ifdef TS_NULL_STUFF_EN
         r_null  <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_psync <= 1'b0;
         r_serr  <= 1'b0;
         r_uf    <= 1'b0;
`ifdef TS_NULL_STUFF_EN
         r_null  <= 1'b0;
`endif
         case (r_state)
            ST_DECIDE: begin
               if (FIFO_EMPTY) begin
`ifdef TS_NULL_STUFF_EN
                  r_state <= ST_NULL;
                  r_cnt   <= '0;
`endif
               end else if (!w_head_sync) begin
                  // only the first discarded word of a run is reported
                  r_serr <= !r_hunt;
                  r_hunt <= 1'b1;
               end else begin
                  r_hunt <= 1'b0;
                  if (w_level_ok) begin
                     r_state <= ST_PASS;
                     r_cnt   <= '0;
                  end
`ifdef TS_NULL_STUFF_EN
                  else begin
                     r_state <= ST_NULL;
                     r_cnt   <= '0;
                  end
`endif
               end
            end
            ST_PASS: begin
               if (!FIFO_EMPTY) begin
                  r_data  <= FIFO_Q[7:0];
                  r_psync <= FIFO_Q[8];
                  r_valid <= 1'b1;
                  r_cnt   <= r_cnt + 8'd1;
                  if (r_cnt == LAST_IDX) begin
                     r_state <= ST_DECIDE;
                  end
               end else begin
                  r_uf <= 1'b1;
               end
            end
`ifdef TS_NULL_STUFF_EN
            ST_NULL: begin
               r_data  <= w_null_byte;
               r_psync <= (r_cnt == 8'd0);
               r_null  <= 1'b1;
               r_valid <= 1'b1;
               r_cnt   <= r_cnt + 8'd1;
               if (r_cnt == LAST_IDX) begin
                  r_state <= ST_DECIDE;
               end
            end
`endif
            default: r_state <= ST_DECIDE;
         endcase
      end
   end

   assign FIFO_RDREQ  = w_rdreq;
   assign DATA_OUT    = r_data;
   assign D_VALID_OUT = r_valid;
   assign P_SYNC_OUT  = r_psync;
   assign SYNC_ERR    = r_serr;
   assign UNDERFLOW   = r_uf;
`ifdef TS_NULL_STUFF_EN
   assign NULL_PKT    = r_null;
`else
   assign NULL_PKT    = 1'b0;
`endif

endmodule
